// File: rtl/temp_i2c_reader.sv
// I2C master that reads the ADT7420 temperature register and outputs the raw
// 13-bit two's-complement code. SCL/SDA are open-drain via pull-low enables.
module temp_i2c_reader #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned SCL_FREQ_HZ = 100_000,
  parameter logic [6:0]  DEV_ADDR    = 7'h4B,
  parameter logic [7:0]  REG_PTR     = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sda_i,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic [12:0] tc,
  output logic        tc_valid,
  output logic        busy,
  output logic        ack_err
);
  localparam int unsigned QDIV  = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
  localparam int unsigned TW    = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [TW-1:0] QLAST = TW'(QDIV - 1);

  localparam logic [2:0] B_ADW = 3'd0, B_PTR = 3'd1, B_ADR = 3'd2, B_MSB = 3'd3, B_LSB = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_RSTART, S_RX_BYTE, S_TX_ACK, S_STOP, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic          samp_q, samp_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    msb_q, msb_d;
  logic [12:0]   tc_q, tc_d;
  logic          tc_valid_q, tc_valid_d;
  logic          ack_err_q, ack_err_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;

  logic       qend, slot_end, samp_pt, low_half;
  logic [7:0] tx_byte;

  always_comb begin
    qend     = (tick_q == QLAST);
    slot_end = qend && (qtr_q == 2'd3);
    samp_pt  = qend && (qtr_q == 2'd2);
    low_half = ~qtr_q[1];

    case (byte_q)
      B_ADW:   tx_byte = {DEV_ADDR, 1'b0};
      B_PTR:   tx_byte = REG_PTR;
      default: tx_byte = {DEV_ADDR, 1'b1};
    endcase

    state_d    = state_q;
    tick_d     = qend ? '0 : tick_q + 1'b1;
    qtr_d      = qend ? qtr_q + 2'd1 : qtr_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    samp_d     = samp_q;
    rx_d       = rx_q;
    msb_d      = msb_q;
    tc_d       = tc_q;
    tc_valid_d = 1'b0;
    ack_err_d  = ack_err_q;

    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_START;
        tick_d    = '0;
        qtr_d     = 2'd0;
        bit_d     = 3'd0;
        ack_err_d = 1'b0;
      end
      S_START: if (slot_end) begin
        state_d = S_TX_BYTE;
        byte_d  = B_ADW;
      end
      S_TX_BYTE: if (slot_end) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_RX_ACK;
      end
      S_RX_ACK: begin
        if (samp_pt) samp_d = sda_i;
        if (slot_end) begin
          if (samp_q) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else begin
            case (byte_q)
              B_ADW:   begin state_d = S_TX_BYTE; byte_d = B_PTR; end
              B_PTR:   state_d = S_RSTART;
              default: begin state_d = S_RX_BYTE; byte_d = B_MSB; end
            endcase
          end
        end
      end
      S_RSTART: if (slot_end) begin
        state_d = S_TX_BYTE;
        byte_d  = B_ADR;
      end
      S_RX_BYTE: begin
        if (samp_pt) rx_d = {rx_q[6:0], sda_i};
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_TX_ACK;
        end
      end
      S_TX_ACK: if (slot_end) begin
        if (byte_q == B_MSB) begin
          msb_d   = rx_q;
          byte_d  = B_LSB;
          state_d = S_RX_BYTE;
        end else begin
          state_d = S_STOP;
        end
      end
      S_STOP: if (slot_end) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        if (!ack_err_q) begin
          tc_d       = {msb_q, rx_q[7:3]};
          tc_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line levels are registered off the current slot/quarter, so both pins
    // move on the same edge and never glitch from state decode.
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_q)
      S_START:   begin scl_oe_d = qtr_q[1];  sda_oe_d = (qtr_q != 2'd0); end
      S_TX_BYTE: begin scl_oe_d = low_half;  sda_oe_d = ~tx_byte[3'd7 - bit_q]; end
      S_RX_ACK,
      S_RX_BYTE: scl_oe_d = low_half;
      S_TX_ACK:  begin scl_oe_d = low_half;  sda_oe_d = (byte_q == B_MSB); end
      S_RSTART:  begin scl_oe_d = (qtr_q == 2'd0) || (qtr_q == 2'd3); sda_oe_d = qtr_q[1]; end
      S_STOP:    begin scl_oe_d = low_half;  sda_oe_d = (qtr_q == 2'd1) || (qtr_q == 2'd2); end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      byte_q     <= 3'd0;
      samp_q     <= 1'b0;
      rx_q       <= 8'd0;
      msb_q      <= 8'd0;
      tc_q       <= 13'd0;
      tc_valid_q <= 1'b0;
      ack_err_q  <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      samp_q     <= samp_d;
      rx_q       <= rx_d;
      msb_q      <= msb_d;
      tc_q       <= tc_d;
      tc_valid_q <= tc_valid_d;
      ack_err_q  <= ack_err_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign scl_oe   = scl_oe_q;
  assign sda_oe   = sda_oe_q;
  assign tc       = tc_q;
  assign tc_valid = tc_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_temp_i2c_reader.sv
// Directed bench for temp_i2c_reader with a behavioural ADT7420 slave on
// pulled-up SCL/SDA; QDIV shrunk to 4 so a transaction is 768 cycles.
module tb_temp_i2c_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sda_i;
  logic        scl_oe, sda_oe, tc_valid, busy, ack_err;
  logic [12:0] tc;

  temp_i2c_reader #(.CLK_FREQ_HZ(1_600_000), .SCL_FREQ_HZ(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sda_i(sda_i),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .tc(tc), .tc_valid(tc_valid),
    .busy(busy), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int tv_cnt = 0;
  always @(posedge clk) if (tc_valid) tv_cnt++;

  // Slave model: log codes 0x100 START, 0x101 repeated START, 0x102 STOP,
  // 0x200|bit master ACK/NACK, otherwise a byte written by the master.
  logic       s_low = 1'b0, s_nack = 1'b0;
  logic [7:0] s_msb = 8'h00, s_lsb = 8'h00, s_sh = 8'h00, s_tx = 8'h00;
  logic       s_active = 1'b0, s_skip = 1'b0, s_rd = 1'b0, s_rd_req = 1'b0;
  logic       s_acked = 1'b0, s_mack = 1'b1;
  int         s_bit = 0, s_byte = 0;
  logic       p_scl = 1'b1, p_sda = 1'b1, b_scl, b_sda;
  int         s_log[$];

  assign sda_i = ~(sda_oe | s_low);

  always @(negedge clk) begin
    b_scl = ~scl_oe;
    b_sda = ~(sda_oe | s_low);
    if (!rst_n) begin
      s_low = 1'b0; s_active = 1'b0; s_rd = 1'b0; s_skip = 1'b0; s_bit = 0;
    end else if (p_scl && b_scl && p_sda && !b_sda) begin
      s_log.push_back(s_active ? 32'h101 : 32'h100);
      s_active = 1'b1; s_skip = 1'b1; s_bit = 0; s_byte = 0;
      s_rd = 1'b0; s_rd_req = 1'b0; s_low = 1'b0;
    end else if (p_scl && b_scl && !p_sda && b_sda) begin
      s_log.push_back(32'h102);
      s_active = 1'b0; s_rd = 1'b0; s_low = 1'b0;
    end else if (s_active && !p_scl && b_scl) begin
      if (s_bit < 8) s_sh = {s_sh[6:0], b_sda};
      else if (s_rd) begin s_mack = b_sda; s_log.push_back(32'h200 | int'(b_sda)); end
    end else if (s_active && p_scl && !b_scl) begin
      if (s_skip) s_skip = 1'b0;
      else if (s_bit < 8) begin
        s_bit++;
        if (s_bit == 8) begin
          if (s_rd) s_low = 1'b0;
          else begin
            s_log.push_back(int'(s_sh));
            s_acked = (s_byte != 0) || (s_sh[7:1] == 7'h4B && !s_nack);
            if (s_byte == 0) s_rd_req = s_sh[0];
            s_low = s_acked;
          end
        end else if (s_rd) s_low = ~s_tx[7 - s_bit];
      end else begin
        s_bit = 0; s_low = 1'b0;
        if (!s_rd && s_byte == 0 && s_rd_req && s_acked) begin
          s_rd = 1'b1; s_tx = s_msb; s_low = ~s_tx[7];
        end else if (s_rd && !s_mack) begin
          s_tx = s_lsb; s_low = ~s_tx[7];
        end else s_rd = 1'b0;
        s_byte++;
      end
    end
    p_scl = b_scl;
    p_sda = ~(sda_oe | s_low);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int log_count(input int code);
    int n = 0;
    foreach (s_log[i]) if (s_log[i] == code) n++;
    return n;
  endfunction

  // Pulses start, then waits for tc_valid or busy dropping (bounded).
  task automatic run_txn(input logic [7:0] msb, input logic [7:0] lsb, input int extra_at,
                         input bit hold_end, input int abort_at, output int lat);
    s_msb = msb; s_lsb = lsb;
    s_log.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ack_err_cleared", ack_err, 0);
    lat = 0;
    while (busy && !tc_valid && lat < 2000 && lat != abort_at) begin
      start = (lat == extra_at) || (hold_end && lat >= 760);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic txn_ok(input string tag, input logic [7:0] msb, input logic [7:0] lsb,
                        input logic [12:0] exp_tc);
    int lat, tv0;
    tv0 = tv_cnt;
    run_txn(msb, lsb, -1, 1'b0, -1, lat);
    chk({tag, "_latency_ok"}, 32'(lat >= 768 && lat <= 772), 1);
    repeat (3) @(negedge clk);
    chk({tag, "_tc"}, 32'(tc), 32'(exp_tc));
    chk({tag, "_ack_err"}, ack_err, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_tv_pulses"}, tv_cnt - tv0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, tv0;
    int exp_log[8];
    exp_log = '{32'h100, 32'h96, 32'h00, 32'h101, 32'h97, 32'h200, 32'h201, 32'h102};

    // 1: reset held, then released
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_tc", 32'(tc), 0);
    chk("rst_tc_valid", tc_valid, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_scl_oe", scl_oe, 0);
    chk("idle_sda_oe", sda_oe, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ack_err", ack_err, 0);

    // 2: +25.0 C and the bus sequence seen by the slave
    txn_ok("p25", 8'h0C, 8'h80, 13'h0190);
    chk("log_len", s_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("log_%0d", i), (i < s_log.size()) ? s_log[i] : 32'hDEAD, exp_log[i]);

    // 3: negative codes; flag bits in the LSB are discarded
    txn_ok("m1", 8'hFF, 8'h80, 13'h1FF0);
    txn_ok("m55", 8'hE4, 8'h87, 13'h1C90);

    // 4: address NACK, then recovery
    s_nack = 1'b1;
    tv0 = tv_cnt;
    run_txn(8'h19, 8'h07, -1, 1'b0, -1, lat);
    chk("nack_finished", 32'(lat < 2000), 1);
    repeat (3) @(negedge clk);
    s_nack = 1'b0;
    chk("nack_ack_err", ack_err, 1);
    chk("nack_tc_held", 32'(tc), 32'h1C90);
    chk("nack_no_tv", tv_cnt - tv0, 0);
    chk("nack_log_len", s_log.size(), 3);
    chk("nack_stop_seen", (s_log.size() > 0) ? s_log[s_log.size()-1] : 32'hDEAD, 32'h102);
    txn_ok("recover", 8'h19, 8'h07, 13'h0320);

    // 5: starts while busy and during DONE are ignored
    tv0 = tv_cnt;
    run_txn(8'h00, 8'h08, 100, 1'b1, -1, lat);
    repeat (2) @(negedge clk);
    chk("busy_start_not_taken", busy, 0);
    repeat (900) @(negedge clk);
    chk("busy_tv_pulses", tv_cnt - tv0, 1);
    chk("busy_one_start", log_count(32'h100), 1);
    chk("busy_tc", 32'(tc), 32'h0001);
    chk("busy_idle_end", busy, 0);

    // 6: reset in the middle of the MSB read
    run_txn(8'h0C, 8'h80, -1, 1'b0, 496, lat);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_scl_oe", scl_oe, 0);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tc", 32'(tc), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    txn_ok("post_rst", 8'hE4, 8'h80, 13'h1C90);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
